hamming_encoder_tx: RTL and testbench
=====================================

// Module: hamming_encoder_tx
// PURPOSE
// - Transmit side of the SECDED Hamming(16,11) link. Accepts 11-bit data words over a valid/ready handshake.
// - Builds the 16-bit codeword in the same bit layout the decoder expects.
// - Serialises the codeword one bit per clock with frame markers.
// - Optional per-frame XOR error injection lets the downstream decoder's single- and double-error paths be exercised.
// PARAMETERS
// - MSB_FIRST  1  1: serialise code[15] first; 0: serialise code[0] first.
// - IDLE_GAP   0  idle cycles (0..15) forced between frames; 0 allows back-to-back frames.
// PORTS
// - clk        in   1   clock; all logic on rising edge
// - rst        in   1   synchronous, active-high reset
// - in_valid   in   1   in_data is valid
// - in_ready   out  1   block can accept a word this cycle
// - in_data    in   11  payload word d[10:0]
// - inj_mask   in   16  XOR mask applied to the transmitted frame (0 = clean); sampled with in_data
// - tx_valid   out  1   tx_bit carries a frame bit this cycle
// - tx_bit     out  1   serial codeword bit
// - tx_sof     out  1   first bit of frame (qualified by tx_valid)
// - tx_eof     out  1   last (16th) bit of frame (qualified by tx_valid)
// - code_word  out  16  clean (uninjected) codeword of the frame in flight; held after frame end
// BEHAVIOUR
// - Codeword layout:
//   - code[15:9]=d[10:4], code[7:5]=d[3:1], code[3]=d[0].
//   - code[1]=^(code&16'hAAA8), code[2]=^(code&16'hCCC8), code[4]=^(code&16'hF0E0), code[8]=^(code&16'hFE00). Masks are evaluated over the data bits only.
//   - code[0]=^code[15:1] (overall even parity). Frame shifted out = code ^ inj_mask.
// - Reset values:
//   - in_ready=0 during reset; it rises the first cycle after rst deasserts.
//   - tx_valid=0, tx_bit=0, tx_sof=0, tx_eof=0, code_word=16'h0000.
//   - FSM=IDLE, bit counter=0.
// - FSM IDLE:
//   - in_ready=1, tx_valid=0.
//   - On in_valid&&in_ready at edge N: capture shift reg = code^inj_mask and code_word = code; go to SHIFT.
// - FSM SHIFT:
//   - tx_valid=1 for exactly 16 consecutive cycles, N+1..N+16.
//   - 4-bit counter runs 0..15. tx_sof=1 when count==0; tx_eof=1 when count==15.
//   - Bit order is set by MSB_FIRST. All tx outputs are registered.
// - End of frame:
//   - If IDLE_GAP==0: in_ready=1 during the eof cycle. A handshake there starts the next frame's sof in the very next cycle, with no bubble. Otherwise go to IDLE.
//   - If IDLE_GAP>0: go to GAP after eof.
// - FSM GAP:
//   - in_ready=0, tx_valid=0 for IDLE_GAP cycles, then IDLE.
// - in_ready is 0 in SHIFT except in the eof cycle when IDLE_GAP==0.
// - in_data and inj_mask are ignored when no handshake occurs. Held in_valid without in_ready creates no extra frames.
// - tx_bit is driven 0 whenever tx_valid=0.
// - Reset mid-frame aborts the frame: all outputs take reset values the cycle after rst is sampled high. No partial frame resumes.
// - Counter wraps 15->0 only on a back-to-back frame start; otherwise it is cleared on entry to IDLE.
// TESTING
// - Reset mid-frame: reset asserted at bit 7 -> next cycle tx_valid=0, code_word=0; next frame after reset is complete and correct.
// - d=11'h000, mask=0, MSB_FIRST=1 -> code_word=16'h0000; 16 zero bits; sof at bit 1, eof at bit 16; latency 1 cycle after handshake.
// - d=11'h7FF -> 16'hFFFF. d=11'h001 -> 16'h000F. d=11'h400 -> 16'h8117. Check the serial stream against code_word, MSB first.
// - Back-to-back: IDLE_GAP=0, in_valid held high with 3 words -> 48 contiguous tx_valid cycles. sof every 16 cycles, no gaps. in_ready high only in the IDLE cycle and eof cycles.
// - Injection: d=11'h400, inj_mask=16'h0020 -> serial frame 16'h8137 with code_word=16'h8117; decoder flags one_error and recovers 11'h400. inj_mask=16'h0006 -> decoder flags two_errors.
// - IDLE_GAP=3: two queued words -> exactly 3 cycles with tx_valid=0 and in_ready=0 between frame eof and the next IDLE cycle.

Source files
------------

// File: rtl/hamming_encoder_tx.sv
// Purpose: SECDED Hamming(16,11) encoder with a 1-bit serialiser, sof/eof markers and XOR error injection.
// Latency: first frame bit (with sof) is presented the cycle after the input handshake; a frame is 16 cycles.
// Backpressure: in_ready is low while a frame shifts (except its eof cycle when IDLE_GAP==0) and during the idle gap.
module hamming_encoder_tx #(
  parameter int MSB_FIRST = 1,  // 1: code[15] goes out first, 0: code[0] goes out first
  parameter int IDLE_GAP  = 0   // forced idle cycles between frames (0..15)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [10:0] in_data,
  input  logic [15:0] inj_mask,
  output logic        tx_valid,
  output logic        tx_bit,
  output logic        tx_sof,
  output logic        tx_eof,
  output logic [15:0] code_word
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Last value of the gap counter before returning to IDLE.
  localparam logic [3:0] GAP_LAST     = (IDLE_GAP > 0) ? 4'(IDLE_GAP - 1) : 4'd0;
  // With no gap, the eof cycle may accept the next word so frames abut.
  localparam bit         BACK_TO_BACK = (IDLE_GAP == 0);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  bit_cnt;
  logic [3:0]  bit_cnt_nxt;
  logic [3:0]  gap_cnt;
  logic [3:0]  gap_cnt_nxt;
  logic [15:0] enc_code;
  logic [15:0] frame_nxt;
  logic [15:0] frame_q;
  logic        load;
  logic        advance;

  // Serial position -> codeword bit index, honouring the configured bit order.
  function automatic logic pick_bit(input logic [15:0] frame, input logic [3:0] pos);
    logic [3:0] idx;
    idx = (MSB_FIRST != 0) ? (4'd15 - pos) : pos;
    return frame[idx];
  endfunction

  // Build the clean codeword: scatter data bits, then parity over data bits, then overall parity.
  always_comb begin : encode
    logic [15:0] c;
    c       = '0;
    c[15:9] = in_data[10:4];
    c[7:5]  = in_data[3:1];
    c[3]    = in_data[0];
    // The masks cover data positions only, so the order of these four is irrelevant.
    c[1]    = ^(c & 16'hAAA8);
    c[2]    = ^(c & 16'hCCC8);
    c[4]    = ^(c & 16'hF0E0);
    c[8]    = ^(c & 16'hFE00);
    // Overall even parity over everything above it, including the Hamming bits.
    c[0]    = ^c[15:1];
    enc_code = c;
  end

  assign frame_nxt = enc_code ^ inj_mask;

  // Next-state logic, handshake ready and counter updates.
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    gap_cnt_nxt = gap_cnt;
    in_ready    = 1'b0;
    load        = 1'b0;
    advance     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        // Gate with rst so a held in_valid cannot slip a word in while reset is asserted.
        in_ready    = !rst;
        bit_cnt_nxt = 4'd0;
        if (in_valid && in_ready) begin
          load      = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bit_cnt != 4'd15) begin
          advance     = 1'b1;
          bit_cnt_nxt = bit_cnt + 4'd1;
        end else if (BACK_TO_BACK) begin
          in_ready = !rst;
          if (in_valid && in_ready) begin
            // Counter wraps 15 -> 0 straight into the next frame's sof.
            load        = 1'b1;
            bit_cnt_nxt = bit_cnt + 4'd1;
          end else begin
            state_nxt   = ST_IDLE;
            bit_cnt_nxt = 4'd0;
          end
        end else begin
          state_nxt   = ST_GAP;
          bit_cnt_nxt = 4'd0;
          gap_cnt_nxt = 4'd0;
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nxt   = ST_IDLE;
          gap_cnt_nxt = 4'd0;
        end else begin
          gap_cnt_nxt = gap_cnt + 4'd1;
        end
      end
      default: begin
        state_nxt   = ST_IDLE;
        bit_cnt_nxt = 4'd0;
        gap_cnt_nxt = 4'd0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      bit_cnt <= 4'd0;
      gap_cnt <= 4'd0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      gap_cnt <= gap_cnt_nxt;
    end
  end

  // Registered serial outputs; tx_* always describe the bit at the current counter position.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_q   <= 16'h0000;
      code_word <= 16'h0000;
      tx_valid  <= 1'b0;
      tx_bit    <= 1'b0;
      tx_sof    <= 1'b0;
      tx_eof    <= 1'b0;
    end else if (load) begin
      frame_q   <= frame_nxt;
      code_word <= enc_code;
      tx_valid  <= 1'b1;
      tx_sof    <= 1'b1;
      tx_eof    <= 1'b0;
      tx_bit    <= pick_bit(frame_nxt, 4'd0);
    end else if (advance) begin
      tx_valid  <= 1'b1;
      tx_sof    <= 1'b0;
      tx_eof    <= (bit_cnt_nxt == 4'd15);
      tx_bit    <= pick_bit(frame_q, bit_cnt_nxt);
    end else begin
      // Idle or gap: no frame bit, and the line is held low.
      tx_valid  <= 1'b0;
      tx_sof    <= 1'b0;
      tx_eof    <= 1'b0;
      tx_bit    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hamming_encoder_tx.sv
// Testbench for hamming_encoder_tx: two instances (MSB first / no gap, LSB first / gap of 3)
// driven with directed and random words; a cycle-level behavioural model checks every output.
module tb_hamming_encoder_tx;

  localparam int GAP_B = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [10:0] in_data   [2];
  logic [15:0] inj_mask  [2];
  logic        tx_valid  [2];
  logic        tx_bit    [2];
  logic        tx_sof    [2];
  logic        tx_eof    [2];
  logic [15:0] code_word [2];

  hamming_encoder_tx #(.MSB_FIRST(1), .IDLE_GAP(0)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .inj_mask(inj_mask[0]), .tx_valid(tx_valid[0]),
    .tx_bit(tx_bit[0]), .tx_sof(tx_sof[0]), .tx_eof(tx_eof[0]), .code_word(code_word[0])
  );

  hamming_encoder_tx #(.MSB_FIRST(0), .IDLE_GAP(GAP_B)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .inj_mask(inj_mask[1]), .tx_valid(tx_valid[1]),
    .tx_bit(tx_bit[1]), .tx_sof(tx_sof[1]), .tx_eof(tx_eof[1]), .code_word(code_word[1])
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Textbook Hamming: data fills non-power-of-two positions in ascending order; parity at 2^b
  // covers every position whose index has bit b set; bit 0 makes the whole word even.
  function automatic logic [15:0] ref_encode(input logic [10:0] d);
    logic [15:0] c;
    int k;
    logic par;
    c = '0;
    k = 0;
    for (int p = 1; p < 16; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p] = d[k];
        k++;
      end
    end
    for (int b = 0; b < 4; b++) begin
      par = 1'b0;
      for (int p = 1; p < 16; p++)
        if (((p >> b) & 1) == 1 && p != (1 << b)) par ^= c[p];
      c[1 << b] = par;
    end
    par = 1'b0;
    for (int p = 1; p < 16; p++) par ^= c[p];
    c[0] = par;
    return c;
  endfunction

  // SECDED decode: syndrome = XOR of set-bit positions; odd overall parity means one error.
  function automatic void ref_decode(input logic [15:0] r, output logic one, output logic two,
                                     output logic [10:0] d);
    int syn;
    int k;
    logic [15:0] w;
    syn = 0;
    for (int p = 1; p < 16; p++) if (r[p]) syn ^= p;
    one = ^r;
    two = !one && (syn != 0);
    w = r;
    if (one) w[syn] = ~w[syn];
    k = 0;
    d = '0;
    for (int p = 1; p < 16; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[k] = w[p];
        k++;
      end
    end
  endfunction

  function automatic int gap_of(input int k);
    return (k == 0) ? 0 : GAP_B;
  endfunction

  function automatic bit msb_of(input int k);
    return (k == 0);
  endfunction

  // Model state: m_pos = serial position of the bit on the line (-1 when no frame).
  int          m_pos       [2] = '{-1, -1};
  int          m_gap       [2] = '{0, 0};
  logic [15:0] m_frame     [2];
  logic [15:0] m_code      [2] = '{16'h0, 16'h0};
  logic [15:0] rx_acc      [2];
  logic [15:0] rx_last     [2];
  int          frames_done [2] = '{0, 0};
  int          run_len     [2] = '{0, 0};
  int          max_run     [2] = '{0, 0};
  int          sof_cnt     [2] = '{0, 0};
  int          gap_seen    [2] = '{0, 0};
  int          last_gap    [2] = '{-1, -1};
  bit          gap_track   [2] = '{1'b0, 1'b0};
  bit          mon_on = 1'b0;

  task automatic mon_step(input int k);
    bit exp_vld;
    bit exp_rdy;
    bit hs;
    int bi;
    if (rst) begin
      m_pos[k] = -1; m_gap[k] = 0; m_code[k] = 16'h0;
      run_len[k] = 0; gap_track[k] = 1'b0;
      return;
    end
    exp_vld = (m_pos[k] >= 0);
    exp_rdy = (gap_of(k) == 0) ? (m_pos[k] < 0 || m_pos[k] == 15)
                               : (m_pos[k] < 0 && m_gap[k] == 0);
    check($sformatf("in_ready[%0d]", k), in_ready[k], exp_rdy);
    check($sformatf("tx_valid[%0d]", k), tx_valid[k], exp_vld);
    check($sformatf("code_word[%0d]", k), code_word[k], m_code[k]);
    if (exp_vld) begin
      bi = msb_of(k) ? 15 - m_pos[k] : m_pos[k];
      check($sformatf("tx_bit[%0d] pos%0d", k, m_pos[k]), tx_bit[k], m_frame[k][bi]);
      check($sformatf("tx_sof[%0d]", k), tx_sof[k], m_pos[k] == 0);
      check($sformatf("tx_eof[%0d]", k), tx_eof[k], m_pos[k] == 15);
      rx_acc[k][bi] = tx_bit[k];
    end else begin
      check($sformatf("idle_bit[%0d]", k), {tx_bit[k], tx_sof[k], tx_eof[k]}, 3'b000);
    end
    // Observed statistics for the directed checks in the main sequence.
    if (tx_valid[k]) begin
      run_len[k]++;
      if (run_len[k] > max_run[k]) max_run[k] = run_len[k];
      if (tx_sof[k]) sof_cnt[k]++;
    end else begin
      run_len[k] = 0;
    end
    if (tx_valid[k] && tx_eof[k]) begin
      gap_track[k] = 1'b1; gap_seen[k] = 0;
    end else if (gap_track[k] && !tx_valid[k]) begin
      if (in_ready[k]) begin
        last_gap[k] = gap_seen[k]; gap_track[k] = 1'b0;
      end else begin
        gap_seen[k]++;
      end
    end
    // Advance the model one cycle.
    hs = in_valid[k] && exp_rdy;
    if (m_pos[k] >= 0) begin
      if (m_pos[k] == 15) begin
        rx_last[k] = rx_acc[k];
        frames_done[k]++;
        m_pos[k] = -1;
        m_gap[k] = gap_of(k);
      end else begin
        m_pos[k]++;
      end
    end else if (m_gap[k] > 0) begin
      m_gap[k]--;
    end
    if (hs) begin
      m_code[k]  = ref_encode(in_data[k]);
      m_frame[k] = m_code[k] ^ inj_mask[k];
      m_pos[k]   = 0;
      rx_acc[k]  = 16'h0;
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      mon_step(0);
      mon_step(1);
    end
  end

  task automatic send(input int k, input logic [10:0] d, input logic [15:0] m, input bit hold);
    int waited;
    waited = 0;
    in_valid[k] = 1'b1;
    in_data[k]  = d;
    inj_mask[k] = m;
    forever begin
      @(negedge clk);
      if (in_ready[k]) break;
      waited++;
      if (waited > 100) begin
        check($sformatf("send_timeout[%0d]", k), in_ready[k], 1'b1);
        break;
      end
    end
    @(posedge clk); #1;
    if (!hold) begin
      in_valid[k] = 1'b0;
      in_data[k]  = 11'($urandom);
      inj_mask[k] = 16'($urandom);
    end
  endtask

  task automatic wait_idle(input int k);
    int waited;
    waited = 0;
    while (m_pos[k] >= 0 || m_gap[k] > 0) begin
      @(posedge clk); #1;
      waited++;
      if (waited > 200) begin
        check($sformatf("idle_timeout[%0d]", k), m_pos[k], 32'hFFFF_FFFF);
        break;
      end
    end
  endtask

  logic [10:0] dir_d [4] = '{11'h000, 11'h7FF, 11'h001, 11'h400};
  logic [15:0] dir_c [4] = '{16'h0000, 16'hFFFF, 16'h000F, 16'h8117};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_tests);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        one;
    logic        two;
    logic [10:0] dd;
    int          base_sof;
    int          base_done;
    int          sent [2];
    logic [10:0] w;
    logic [15:0] msk;
    int          nb;
    int          k;

    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0; in_data[i] = 11'h0; inj_mask[i] = 16'h0;
    end
    rst = 1'b1;
    mon_on = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_in_ready[%0d]", i), in_ready[i], 1'b0);
      check($sformatf("rst_tx_valid[%0d]", i), tx_valid[i], 1'b0);
      check($sformatf("rst_tx_bits[%0d]", i), {tx_bit[i], tx_sof[i], tx_eof[i]}, 3'b000);
      check($sformatf("rst_code_word[%0d]", i), code_word[i], 16'h0000);
    end
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", in_ready[0], 1'b1);
    @(posedge clk); #1;

    // Directed codewords, MSB first; sof one cycle after the handshake.
    for (int i = 0; i < 4; i++) begin
      send(0, dir_d[i], 16'h0, 1'b0);
      if (i == 0) check("latency_sof", {tx_valid[0], tx_sof[0]}, 2'b11);
      wait_idle(0);
      check($sformatf("code_word_d%0h", dir_d[i]), code_word[0], dir_c[i]);
      check($sformatf("rx_frame_d%0h", dir_d[i]), rx_last[0], dir_c[i]);
    end

    // Error injection: single flipped bit, then two flipped bits.
    send(0, 11'h400, 16'h0020, 1'b0);
    wait_idle(0);
    check("inj1_rx", rx_last[0], 16'h8137);
    check("inj1_code", code_word[0], 16'h8117);
    ref_decode(rx_last[0], one, two, dd);
    check("inj1_flags", {one, two}, 2'b10);
    check("inj1_data", dd, 11'h400);
    send(0, 11'h400, 16'h0006, 1'b0);
    wait_idle(0);
    ref_decode(rx_last[0], one, two, dd);
    check("inj2_flags", {one, two}, 2'b01);

    // Back-to-back: three words with in_valid held high.
    base_sof = sof_cnt[0];
    max_run[0] = 0;
    send(0, 11'($urandom), 16'h0, 1'b1);
    send(0, 11'($urandom), 16'h0, 1'b1);
    send(0, 11'($urandom), 16'h0, 1'b0);
    wait_idle(0);
    check("b2b_run", max_run[0], 48);
    check("b2b_sofs", sof_cnt[0] - base_sof, 3);

    // Reset in the middle of a frame (bit 7 on the line).
    send(0, 11'h5A5, 16'h0, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_tx_valid", tx_valid[0], 1'b0);
    check("midrst_code_word", code_word[0], 16'h0000);
    check("midrst_in_ready", in_ready[0], 1'b0);
    rst = 1'b0;
    base_done = frames_done[0];
    send(0, 11'h2C3, 16'h0, 1'b0);
    wait_idle(0);
    check("postrst_frames", frames_done[0] - base_done, 1);
    check("postrst_rx", rx_last[0], ref_encode(11'h2C3));

    // Gap of 3 between two queued words, LSB first.
    send(1, 11'h001, 16'h0, 1'b1);
    send(1, 11'h400, 16'h0, 1'b0);
    wait_idle(1);
    check("gap_len", last_gap[1], GAP_B);
    check("gap_rx", rx_last[1], 16'h8117);

    // Random bursts on either instance.
    base_done = frames_done[0] + frames_done[1];
    sent[0] = 0; sent[1] = 0;
    for (int it = 0; it < 40; it++) begin
      k  = $urandom_range(0, 1);
      nb = $urandom_range(1, 4);
      for (int j = 0; j < nb; j++) begin
        w = 11'($urandom);
        case ($urandom_range(0, 3))
          0:       msk = 16'h0001 << $urandom_range(0, 15);
          1:       msk = (16'h0001 << $urandom_range(0, 7)) | (16'h0100 << $urandom_range(0, 7));
          default: msk = 16'h0;
        endcase
        send(k, w, msk, j != nb - 1);
        sent[k]++;
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    wait_idle(0);
    wait_idle(1);
    check("rand_frames", frames_done[0] + frames_done[1] - base_done, sent[0] + sent[1]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
